// File: rtl/muxn_pkg.sv
// muxn_pipe shared definitions: mode encodings
// and the rotated-priority index helper.
package muxn_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int rot_idx(
    input int base,
    input int off,
    input int n
  );
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/muxn_if.sv
// muxn_pipe channel bundle: per-channel valid/ready inputs,
// registered output handshake. MUXN_PARITY_EN adds out_par.
interface muxn_if #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4
);
  localparam int SEL_W = $clog2(N_CH);

  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;
`ifdef MUXN_PARITY_EN
  logic                  out_par;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_par
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_par
  );
`else
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
`endif

endinterface

// File: rtl/muxn_rr_arb.sv
// muxn_pipe round-robin arbiter: first valid channel
// scanning upward from ptr with wrap. Purely combinational.
module muxn_rr_arb
  import muxn_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_v
);

  logic [SEL_W-1:0] idx;

  // lowest rotated offset with a valid request wins
  always_comb begin
    gnt   = '0;
    gnt_v = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = SEL_W'(rot_idx(int'(ptr), k, N_CH));
      if (!gnt_v && valid[idx]) begin
        gnt   = idx;
        gnt_v = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe: N-channel registered mux, fixed or round-robin
// select. Define MUXN_PARITY_EN to add registered out_par.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input logic  clk,
  input logic  rst_n,
  muxn_if.slave bus
);

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;
  logic [SEL_W-1:0] rr_ptr;

  logic [SEL_W-1:0] arb_g;
  logic             arb_v;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic             fix_v;
  logic             fix_ok;
  logic             grant_v;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;
  logic [N_CH-1:0]  ready;

  muxn_rr_arb #(.N_CH(N_CH)) u_arb (
    .valid (bus.in_valid),
    .ptr   (rr_ptr),
    .gnt   (arb_g),
    .gnt_v (arb_v)
  );

  assign load_en = !valid_q || bus.out_ready;

  // fixed-select lookup; sel beyond N_CH matches nothing
  always_comb begin
    fix_v  = 1'b0;
    fix_ok = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (SEL_W'(i) == bus.sel) begin
        fix_v  = bus.in_valid[i];
        fix_ok = 1'b1;
      end
    end
  end

  // candidate channel and whether it may be granted
  always_comb begin
    cand    = arb_g;
    cand_ok = arb_v;
    grant_v = arb_v;
    if (bus.mode == MODE_FIXED) begin
      cand    = bus.sel;
      cand_ok = fix_ok;
      grant_v = fix_ok && fix_v;
    end
  end

  assign xfer = load_en && grant_v;

  // data slice and ready one-hot for the candidate
  always_comb begin
    cand_data = '0;
    ready     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (SEL_W'(i) == cand) begin
        cand_data = bus.in_data[i*WIDTH +: WIDTH];
        ready[i]  = rst_n && load_en && cand_ok;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

  // single output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else if (load_en) begin
      if (xfer) begin
        data_q  <= cand_data;
        ch_q    <= cand;
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // round-robin pointer advances past each RR grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && bus.mode == MODE_RR) begin
      rr_ptr <= (cand == SEL_W'(N_CH-1)) ? '0 : cand + 1'b1;
    end
  end

`ifdef MUXN_PARITY_EN
  logic par_q;

  // parity travels with out_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (xfer) begin
      par_q <= ^cand_data;
    end
  end

  assign bus.out_par = par_q;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: directed plus random checks of two muxn_pipe
// instances (4 and 3 channels) against a behavioural model.
module tb_muxn_pipe;
  import muxn_pkg::*;

  typedef struct {
    int v;
    int d;
    int ch;
    int ptr;
    int par;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  muxn_if #(.WIDTH(4), .N_CH(4)) ia();
  muxn_if #(.WIDTH(4), .N_CH(3)) ib();

  muxn_pipe #(.WIDTH(4), .N_CH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  muxn_pipe #(.WIDTH(4), .N_CH(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  int vec  = 0;
  int miss = 0;
  mstate_t ma, mb;

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t r;
    r.v = 0; r.d = 0; r.ch = 0; r.ptr = 0; r.par = 0;
    return r;
  endfunction

  // grant from the selection rules; -1 when nothing granted
  function automatic int grant(input int n, input int mode,
                               input int sel, input int valid,
                               input int ptr);
    int idx;
    if (mode == 0)
      return (sel < n && ((valid >> sel) & 1) == 1) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      idx = (ptr + k) % n;
      if (((valid >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int n, input int mode,
                                   input int sel, input int valid,
                                   input mstate_t s, input int ordy);
    int c;
    if (s.v != 0 && ordy == 0) return 0;
    c = (mode == 0) ? sel : grant(n, mode, sel, valid, s.ptr);
    if (c < 0 || c >= n) return 0;
    return 1 << c;
  endfunction

  function automatic mstate_t mnext(input mstate_t s, input int n,
                                    input int mode, input int sel,
                                    input int valid, input int data,
                                    input int ordy);
    mstate_t r = s;
    int g;
    if (s.v == 0 || ordy != 0) begin
      g = grant(n, mode, sel, valid, s.ptr);
      if (g >= 0) begin
        r.v   = 1;
        r.d   = (data >> (g * 4)) & 15;
        r.ch  = g;
        r.par = $countones(r.d) & 1;
        if (mode != 0) r.ptr = (g + 1) % n;
      end else begin
        r.v = 0;
      end
    end
    return r;
  endfunction

  // one clock: check ready, advance model, check outputs
  task automatic cyc();
    #1;
    chk("a_ready", int'(ia.in_ready),
        exp_ready(4, int'(ia.mode), int'(ia.sel),
                  int'(ia.in_valid), ma, int'(ia.out_ready)));
    chk("b_ready", int'(ib.in_ready),
        exp_ready(3, int'(ib.mode), int'(ib.sel),
                  int'(ib.in_valid), mb, int'(ib.out_ready)));
    @(posedge clk);
    ma = mnext(ma, 4, int'(ia.mode), int'(ia.sel),
               int'(ia.in_valid), int'(ia.in_data),
               int'(ia.out_ready));
    mb = mnext(mb, 3, int'(ib.mode), int'(ib.sel),
               int'(ib.in_valid), int'(ib.in_data),
               int'(ib.out_ready));
    #1;
    chk("a_valid", int'(ia.out_valid), ma.v);
    chk("a_data", int'(ia.out_data), ma.d);
    chk("a_ch", int'(ia.out_ch), ma.ch);
    chk("b_valid", int'(ib.out_valid), mb.v);
    chk("b_data", int'(ib.out_data), mb.d);
    chk("b_ch", int'(ib.out_ch), mb.ch);
`ifdef MUXN_PARITY_EN
    chk("a_par", int'(ia.out_par), ma.par);
    chk("b_par", int'(ib.out_par), mb.par);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_valid"}, int'(ia.out_valid), 0);
    chk({tag, "_a_data"}, int'(ia.out_data), 0);
    chk({tag, "_a_ch"}, int'(ia.out_ch), 0);
    chk({tag, "_a_ready"}, int'(ia.in_ready), 0);
    chk({tag, "_b_valid"}, int'(ib.out_valid), 0);
    chk({tag, "_b_ready"}, int'(ib.in_ready), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ia.mode = MODE_FIXED; ia.sel = 2'd0;
    ia.in_valid = 4'hF; ia.in_data = 16'h0; ia.out_ready = 1'b1;
    ib.mode = MODE_FIXED; ib.sel = 2'd0;
    ib.in_valid = 3'h7; ib.in_data = 12'h0; ib.out_ready = 1'b1;
    ma = mreset();
    mb = mreset();
    #1;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;
    ib.in_valid = 3'h0;

    // load a word, then reset mid-stream
    ia.sel = 2'd1; ia.in_valid = 4'b0010; ia.in_data = 16'h0030;
    cyc();
    chk("pre_rst_valid", int'(ia.out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    ma = mreset();
    mb = mreset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fixed select ch2
    ia.sel = 2'd2; ia.in_valid = 4'b0100; ia.in_data = 16'h0A00;
    cyc();
    chk("t1_data", int'(ia.out_data), 10);
    chk("t1_ch", int'(ia.out_ch), 2);
    chk("t1_valid", int'(ia.out_valid), 1);

    // backpressure
    ia.out_ready = 1'b0; ia.in_data = 16'h0500;
    repeat (3) begin
      cyc();
      chk("t2_hold", int'(ia.out_data), 10);
      chk("t2_ready", int'(ia.in_ready), 0);
    end
    ia.out_ready = 1'b1;
    cyc();
    chk("t2_new", int'(ia.out_data), 5);

    // round-robin fairness
    ia.mode = MODE_RR; ia.in_valid = 4'hF; ia.in_data = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t3_ch", int'(ia.out_ch), k % 4);
      chk("t3_data", int'(ia.out_data), (k % 4) + 1);
      chk("t3_valid", int'(ia.out_valid), 1);
    end

    // skip and wrap
    ia.in_valid = 4'b0100;
    cyc();
    chk("t4_ch2", int'(ia.out_ch), 2);
    ia.in_valid = 4'b0010;
    cyc();
    chk("t4_ch1", int'(ia.out_ch), 1);
    ia.in_valid = 4'b1000;
    cyc();
    chk("t4_ch3", int'(ia.out_ch), 3);
    ia.in_valid = 4'hF;
    cyc();
    chk("t4_wrap", int'(ia.out_ch), 0);

    // invalid select on the 3-channel instance
    ib.mode = MODE_FIXED; ib.sel = 2'd0;
    ib.in_valid = 3'h7; ib.in_data = 12'h007;
    cyc();
    chk("t5_load", int'(ib.out_data), 7);
`ifdef MUXN_PARITY_EN
    chk("t5_par", int'(ib.out_par), 1);
`endif
    ib.sel = 2'd3;
    cyc();
    chk("t5_ready", int'(ib.in_ready), 0);
    chk("t5_drain", int'(ib.out_valid), 0);

    // random traffic
    repeat (400) begin
      ia.mode = 1'($urandom_range(0, 1));
      ia.sel = 2'($urandom_range(0, 3));
      ia.in_valid = 4'($urandom_range(0, 15));
      ia.in_data = 16'($urandom);
      ia.out_ready = ($urandom_range(0, 3) != 0);
      ib.mode = 1'($urandom_range(0, 1));
      ib.sel = 2'($urandom_range(0, 3));
      ib.in_valid = 3'($urandom_range(0, 7));
      ib.in_data = 12'($urandom);
      ib.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input channel and on the output.
- Two selection modes: fixed select (external sel) and round-robin arbitration among valid channels.
- Selects the operand source feeding the 4-bit arithmetic unit datapath.
- Replaces plain combinational 2:1 operand selection where sources are producers with flow control.

Parameters:
- WIDTH, 4: data width per channel, in bits; must be at least 1.
- N_CH, 4: number of input channels; must be at least 2.
- SEL_W, $clog2(N_CH): width of sel and out_ch; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = fixed select (MODE_FIXED); 1 = round-robin (MODE_RR).
- sel  input  SEL_W  channel index, used in MODE_FIXED only.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  registered index of the channel out_data came from.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_data=0, out_ch=0, out_valid=0, rr_ptr=0. in_ready is all 0 while rst_n is low.
- load_en = !out_valid || out_ready. This is a single output register stage.
- Grant, MODE_FIXED: g = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
- Grant, MODE_RR: g = first index with in_valid set, scanning rr_ptr, rr_ptr+1, ..., N_CH-1, 0, ..., rr_ptr-1.
- in_ready[i] = load_en && (i == candidate), where candidate = sel (MODE_FIXED) or g (MODE_RR). in_ready never depends on in_valid[i] of the same channel in MODE_FIXED.
- Transfer in: in_valid[g] && in_ready[g]. On the clock edge, out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- load_en with no grant: out_valid <= 0. out_data and out_ch hold their last values.
- !load_en: out_data, out_ch and out_valid hold.
- Stability: out_data and out_ch are stable while out_valid && !out_ready.
- Latency: 1 cycle from an accepted input to out_valid. Throughput: 1 transfer per cycle while out_ready stays high.
- rr_ptr update: only on an input transfer in MODE_RR, rr_ptr <= (g+1) mod N_CH. The wrap from N_CH-1 goes to 0. rr_ptr holds in MODE_FIXED.
- sel >= N_CH (possible when N_CH is not a power of 2): no channel is ready or granted; output drains normally.
- Mode or sel change: takes effect for the grant in the same cycle. An already registered output is unaffected.
- Simultaneous output drain and input accept: the new word loads, and out_valid stays 1 with no bubble.
- Reset mid-transfer: the pending word is discarded and no partial state is kept.

Optional Feature:
- Macro: MUXN_PARITY_EN.
- Defined: adds output port out_par (1 bit, registered). It loads ^in_data[g] together with out_data, resets to 0, and holds under the same rules as out_data.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package muxn_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1;
  - a function computing the rotated-priority index.
- One natural sub-module: muxn_rr_arb. It is combinational, takes in_valid and rr_ptr, and returns the grant index plus a grant-valid flag.
- Output register, rr_ptr and handshake logic stay in muxn_pipe.

Test Plan:
1. Reset / fixed select (WIDTH=4, N_CH=4):
   - Assert rst_n=0 mid-stream with out_valid=1 → out_valid, out_data and out_ch are 0 immediately.
   - Release reset, MODE_FIXED, sel=2, in_valid=4'b0100, ch2=4'hA, out_ready=1 → next cycle out_data=4'hA, out_ch=2, out_valid=1.
2. Backpressure:
   - out_valid=1, out_ready=0, ch2 valid with 4'h5 → in_ready=0; out_data holds 4'hA for 3 cycles.
   - Raise out_ready → 4'h5 appears the next cycle.
3. Round-robin fairness:
   - MODE_RR, all channels valid with values 1,2,3,4, out_ready=1 → out_ch sequence 0,1,2,3,0 with matching data and no bubbles.
4. Round-robin skip/wrap:
   - rr_ptr=3 after a grant to ch2; only ch1 valid → grant ch1, rr_ptr becomes 2.
   - Then only ch3 valid → grant ch3, rr_ptr wraps to 0.
5. Invalid select (N_CH=3):
   - sel=3, all channels valid → in_ready=0, out_valid drops to 0 after the drain.
   - With MUXN_PARITY_EN: ch0=4'b0111 accepted → out_par=1.
